// File: rtl/fltr_multi_ch.sv
// Multi-channel glitch filter with runtime-programmable threshold.
// Each of CH 1-bit inputs drives a filtered output that only changes after the input
// disagrees with it for thr consecutive samples; one-cycle rise/fall strobes per channel.
// Optional feature: define FLTR_GLITCH_CNT_EN to build per-channel saturating counters of
// aborted runs (adds glitch_clr / glitch_cnt ports).
module fltr_multi_ch #(
    parameter int unsigned  CH    = 8,
    parameter int unsigned  N     = 3,
    parameter int unsigned  N_MAX = 15,
    parameter bit           INIT  = 1'b0,
    parameter int unsigned  GW    = 8,
    localparam int unsigned TW    = $clog2(N_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] in,
    input  logic          cfg_we,
    input  logic [TW-1:0] cfg_thr,
    output logic [TW-1:0] thr_o,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
`ifdef FLTR_GLITCH_CNT_EN
    ,
    input  logic             glitch_clr,
    output logic [CH*GW-1:0] glitch_cnt
`endif
);

    logic [TW-1:0] thr_q, thr_d, thr_clamp;
    logic [TW-1:0] cnt_q [CH];
    logic [TW-1:0] cnt_d [CH];
    logic [CH-1:0] out_q, out_d;
    logic [CH-1:0] rise_q, rise_d;
    logic [CH-1:0] fall_q, fall_d;

    // Clamp a requested threshold into the legal range 1..N_MAX.
    always_comb begin
        thr_clamp = cfg_thr;
        if (cfg_thr == '0) begin
            thr_clamp = TW'(1);
        end else if (32'(cfg_thr) > N_MAX) begin
            thr_clamp = TW'(N_MAX);
        end
    end

    // Per-channel run counting; a config write clears all runs and suppresses toggles.
    always_comb begin
        thr_d  = thr_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = '0;
        end
        if (cfg_we) begin
            thr_d = thr_clamp;
        end
        for (int i = 0; i < CH; i++) begin
            if (!cfg_we && (in[i] != out_q[i])) begin
                if ((cnt_q[i] + TW'(1)) == thr_q) begin
                    out_d[i]  = in[i];
                    rise_d[i] = in[i];
                    fall_d[i] = ~in[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + TW'(1);
                end
            end
        end
    end

    // State registers; synchronous active-low reset has priority over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            thr_q  <= TW'(N);
            out_q  <= {CH{INIT}};
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            thr_q  <= thr_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign thr_o = thr_q;
    assign out   = out_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef FLTR_GLITCH_CNT_EN
    logic [GW-1:0] glitch_q [CH];
    logic [GW-1:0] glitch_d [CH];

    // Count aborted runs (partial run ended by input returning to out); clear wins.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            glitch_d[i] = glitch_q[i];
            if (glitch_clr) begin
                glitch_d[i] = '0;
            end else if (!cfg_we && (in[i] == out_q[i]) && (cnt_q[i] != '0) &&
                         (glitch_q[i] != '1)) begin
                glitch_d[i] = glitch_q[i] + GW'(1);
            end
        end
    end

    // Glitch counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (!reset_n) begin
                glitch_q[i] <= '0;
            end else begin
                glitch_q[i] <= glitch_d[i];
            end
        end
    end

    // Flatten counters onto the output bus, channel i at [i*GW +: GW].
    always_comb begin
        glitch_cnt = '0;
        for (int i = 0; i < CH; i++) begin
            glitch_cnt[i*GW +: GW] = glitch_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fltr_multi_ch.sv
// Self-checking bench for fltr_multi_ch: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural run-length model.
module tb_fltr_multi_ch;

    localparam int unsigned CH    = 8;
    localparam int unsigned N     = 3;
    localparam int unsigned N_MAX = 15;
    localparam bit          INIT  = 1'b0;
    localparam int unsigned GW    = 8;
    localparam int unsigned TW    = $clog2(N_MAX + 1);
    localparam int          GMAX  = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst_s = 1'b0;
    logic [CH-1:0] in_s = '0;
    logic          cfg_we_s = 1'b0;
    logic [TW-1:0] cfg_thr_s = '0;
    logic          gclr_s = 1'b0;
    logic [TW-1:0] thr_o;
    logic [CH-1:0] out_w, rise_w, fall_w;
`ifdef FLTR_GLITCH_CNT_EN
    logic [CH*GW-1:0] gcnt_w;
`endif

    fltr_multi_ch #(
        .CH(CH), .N(N), .N_MAX(N_MAX), .INIT(INIT), .GW(GW)
    ) dut (
        .clk       (clk),
        .reset_n   (rst_s),
        .in        (in_s),
        .cfg_we    (cfg_we_s),
        .cfg_thr   (cfg_thr_s),
        .thr_o     (thr_o),
        .out       (out_w),
        .rise      (rise_w),
        .fall      (fall_w)
`ifdef FLTR_GLITCH_CNT_EN
        ,
        .glitch_clr(gclr_s),
        .glitch_cnt(gcnt_w)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: length of current disagreeing run per channel.
    bit m_out [CH];
    bit m_rise [CH];
    bit m_fall [CH];
    int m_run [CH];
    int m_glitch [CH];
    int m_thr;
    int streak;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (!rst_s) begin
            m_thr = N;
            for (int i = 0; i < CH; i++) begin
                m_out[i] = INIT; m_rise[i] = 0; m_fall[i] = 0;
                m_run[i] = 0; m_glitch[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                m_rise[i] = 0; m_fall[i] = 0;
            end
            if (cfg_we_s) begin
                m_thr = int'(cfg_thr_s);
                if (m_thr < 1) m_thr = 1;
                if (m_thr > N_MAX) m_thr = N_MAX;
                for (int i = 0; i < CH; i++) m_run[i] = 0;
            end else begin
                for (int i = 0; i < CH; i++) begin
                    if (in_s[i] != m_out[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= m_thr) begin
                            m_out[i] = in_s[i];
                            m_run[i] = 0;
                            if (in_s[i]) m_rise[i] = 1; else m_fall[i] = 1;
                        end
                    end else begin
                        if (m_run[i] != 0 && m_glitch[i] < GMAX) m_glitch[i]++;
                        m_run[i] = 0;
                    end
                end
            end
            if (gclr_s) for (int i = 0; i < CH; i++) m_glitch[i] = 0;
        end
    endtask

    task automatic compare();
        logic [CH-1:0] eo, er, ef;
        for (int i = 0; i < CH; i++) begin
            eo[i] = m_out[i]; er[i] = m_rise[i]; ef[i] = m_fall[i];
        end
        chk("out", out_w, eo);
        chk("rise", rise_w, er);
        chk("fall", fall_w, ef);
        chk("thr_o", thr_o, m_thr);
        chk("rise_and_fall_exclusive", rise_w & fall_w, 0);
`ifdef FLTR_GLITCH_CNT_EN
        for (int i = 0; i < CH; i++) chk("glitch_cnt", gcnt_w[i*GW +: GW], m_glitch[i]);
`endif
        if (out_w == eo) streak++; else streak = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_s = 1'b0; step(); rst_s = 1'b1;
    endtask

    task automatic cfg_write(input int unsigned t);
        cfg_we_s = 1'b1; cfg_thr_s = TW'(t); step(); cfg_we_s = 1'b0;
    endtask

    initial begin
        logic [23:0] pat;
        pat = 24'b011100101111110001100000;

        // Reset state
        rst_s = 1'b0; step(); step();
        chk("reset_out", out_w, {CH{INIT}});
        chk("reset_thr", thr_o, N);
        chk("reset_rise", rise_w, 0);
        rst_s = 1'b1;

        // T1: step on ch0, out/rise at the third sample
        in_s[0] = 1'b1;
        step(); chk("t1_out_k", out_w[0], 0);
        step(); chk("t1_out_k1", out_w[0], 0);
        step(); chk("t1_out_k2", out_w[0], 1); chk("t1_rise_k2", rise_w[0], 1);
        step(); chk("t1_rise_k3", rise_w[0], 0); chk("t1_fall_k3", fall_w[0], 0);

        // T2: 2-sample pulse is rejected
        in_s = '0; do_reset();
        in_s[0] = 1'b1; step(); step();
        in_s[0] = 1'b0; step(); step();
        chk("t2_out", out_w[0], 0);
`ifdef FLTR_GLITCH_CNT_EN
        chk("t2_glitch", gcnt_w[0 +: GW], 1);
`endif

        // T3: thr=1 is a plain register; clamping
        cfg_write(1); chk("t3_thr1", thr_o, 1);
        in_s = 8'hA5; step(); chk("t3_follow_a5", out_w, 8'hA5);
        in_s = 8'h3C; step(); chk("t3_follow_3c", out_w, 8'h3C);
        cfg_write(0); chk("t3_thr0_clamp", thr_o, 1);
        cfg_write(15); chk("t3_thr_max", thr_o, 15);

        // T4: config write kills a run about to complete
        in_s = '0; do_reset();
        in_s[0] = 1'b1; step(); step();
        cfg_write(3); chk("t4_out_at_write", out_w[0], 0);
        step(); step(); chk("t4_out_after2", out_w[0], 0);
        step(); chk("t4_out_after3", out_w[0], 1);

        // T5: reset mid-run
        cfg_write(4);
        in_s = '1; repeat (4) step();
        chk("t5_out_high", out_w, 8'hFF);
        in_s = '0; step(); step();
        rst_s = 1'b0; step();
        chk("t5_rst_out", out_w, 0); chk("t5_rst_thr", thr_o, N);
        chk("t5_rst_rise", rise_w, 0); chk("t5_rst_fall", fall_w, 0);
        rst_s = 1'b1;
        in_s = '1; step(); step(); chk("t5_restart_2", out_w, 0);
        step(); chk("t5_restart_3", out_w, 8'hFF);

        // T6: rotating pattern with per-channel phase
        in_s = '0; do_reset();
        streak = 0;
        for (int t = 0; t < 72; t++) begin
            for (int c = 0; c < CH; c++) in_s[c] = pat[23 - ((t + 3 * c) % 24)];
            step();
        end
        chk("t6_streak_ge_24", (streak >= 24) ? 1 : 0, 1);

        // Random traffic with occasional config writes, clears and resets
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < CH; c++) if ($urandom_range(0, 5) == 0) in_s[c] = ~in_s[c];
            cfg_we_s  = ($urandom_range(0, 40) == 0);
            cfg_thr_s = TW'($urandom_range(0, 6));
            gclr_s    = ($urandom_range(0, 60) == 0);
            rst_s     = ($urandom_range(0, 150) != 0);
            step();
        end
        cfg_we_s = 1'b0; gclr_s = 1'b0; rst_s = 1'b1;

`ifdef FLTR_GLITCH_CNT_EN
        // Saturation of the glitch counter on ch0
        in_s = '0; do_reset();
        for (int g = 0; g < GMAX + 4; g++) begin
            in_s[0] = 1'b1; step(); in_s[0] = 1'b0; step();
        end
        chk("glitch_saturate", gcnt_w[0 +: GW], GMAX);
        gclr_s = 1'b1; step(); gclr_s = 1'b0;
        chk("glitch_clear", gcnt_w[0 +: GW], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
